// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Purpose  : Display stage for a 3-digit BCD result plus sign. Captures the
//            value on a load strobe and time-multiplexes it onto a 4-digit
//            common-anode 7-segment display (units, tens, hundreds, sign).
//            All outputs are registered so they can drive board pins directly.
// Ports    : i_clk       system clock
//            i_rst       synchronous active-high reset
//            i_bcd       BCD value: [3:0] units, [7:4] tens, [11:8] hundreds
//            i_negative  value is negative (sign digit shows a minus)
//            i_load      capture strobe for i_bcd / i_negative
//            o_seg       segments {g,f,e,d,c,b,a}, active-low
//            o_dp        decimal point, active-low, held off
//            o_an        digit anodes, active-low, o_an[0] = rightmost digit
// Options  : SEVEN_SEG_ZERO_BLANK_EN - when defined, leading zeros of the
//            hundreds and tens digits are blanked (units always shown).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
  parameter int NB_BCD      = 12,
  parameter int REFRESH_DIV = 100000,
  parameter int NB_DIV      = $clog2(REFRESH_DIV) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_BCD-1:0] i_bcd,
  input  logic              i_negative,
  input  logic              i_load,
  output logic [6:0]        o_seg,
  output logic              o_dp,
  output logic [3:0]        o_an
);

  localparam logic [NB_DIV-1:0] DIV_LAST  = NB_DIV'(REFRESH_DIV - 1);
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;
  localparam logic [6:0]        SEG_MINUS = 7'b0111111;

  logic [NB_BCD-1:0] bcd_q;
  logic              neg_q;
  logic [NB_DIV-1:0] div_cnt;
  logic [1:0]        digit_idx;
  logic              blank_hund;
  logic              blank_tens;
  logic [6:0]        seg_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0000110;  // non-BCD nibble shows "E"
    endcase
    return seg;
  endfunction

  // Capture register: reset has priority over a simultaneous load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcd_q <= '0;
      neg_q <= 1'b0;
    end else if (i_load) begin
      bcd_q <= i_bcd;
      neg_q <= i_negative;
    end
  end

  // Refresh divider; the digit index advances on the wrap cycle only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt   <= '0;
      digit_idx <= 2'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      div_cnt   <= div_cnt + NB_DIV'(1);
    end
  end

  // Leading-zero blanking looks at the captured value, not the live input.
`ifdef SEVEN_SEG_ZERO_BLANK_EN
  assign blank_hund = (bcd_q[11:8] == 4'd0);
  assign blank_tens = blank_hund && (bcd_q[7:4] == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    seg_next = SEG_BLANK;
    case (digit_idx)
      2'd0:    seg_next = decode(bcd_q[3:0]);
      2'd1:    seg_next = blank_tens ? SEG_BLANK : decode(bcd_q[7:4]);
      2'd2:    seg_next = blank_hund ? SEG_BLANK : decode(bcd_q[11:8]);
      default: seg_next = neg_q ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  // Output register: one cycle behind the digit index, so anode and segment
  // pattern always change together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an  <= 4'b1111;
      o_seg <= SEG_BLANK;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= ~(4'b0001 << digit_idx);
      o_seg <= seg_next;
      o_dp  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Purpose  : Scoreboard bench for seven_seg_scan. A REFRESH_DIV=4 instance is
//            checked digit by digit against hand-computed segment tables; a
//            REFRESH_DIV=1 instance is checked for per-cycle anode rotation.
// Options  : SEVEN_SEG_ZERO_BLANK_EN selects the blanked expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bcd;
  logic        neg;
  logic        load;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = 0;
  int base        = 0;
  int cur         = 0;

`ifdef SEVEN_SEG_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'b1111111;
`else
  localparam logic [6:0] Z = 7'b1000000;
`endif

  // Vector table: captured value and expected {units, tens, hundreds, sign}.
  localparam logic [11:0] V_BCD [6] = '{12'h000, 12'h127, 12'h005, 12'h0A0, 12'hF38, 12'h406};
  localparam logic        V_NEG [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [6:0]  V_SEG [6][4] = '{
    '{7'b1000000, Z,          Z,          7'b1111111},
    '{7'b1111000, 7'b0100100, 7'b1111001, 7'b1111111},
    '{7'b0010010, Z,          Z,          7'b0111111},
    '{7'b1000000, 7'b0000110, Z,          7'b1111111},
    '{7'b0000000, 7'b0110000, 7'b0000110, 7'b0111111},
    '{7'b0000010, 7'b1000000, 7'b0011001, 7'b1111111}
  };

  typedef struct {
    int         due;
    bit         on_div1;
    logic [3:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t sb[$];

  seven_seg_scan #(.NB_BCD(12), .REFRESH_DIV(4)) u_div4 (
    .i_clk(clk), .i_rst(rst), .i_bcd(bcd), .i_negative(neg), .i_load(load),
    .o_seg(seg0), .o_dp(dp0), .o_an(an0)
  );

  seven_seg_scan #(.NB_BCD(12), .REFRESH_DIV(1)) u_div1 (
    .i_clk(clk), .i_rst(rst), .i_bcd(bcd), .i_negative(neg), .i_load(load),
    .o_seg(seg1), .o_dp(dp1), .o_an(an1)
  );

  always #5 clk = ~clk;

  function automatic void push_reset(input int n);
    exp_t e;
    e.due = n; e.on_div1 = 1'b0; e.an = 4'b1111; e.seg = 7'b1111111; e.name = "reset";
    sb.push_back(e);
  endfunction

  // Expected output of the DIV=4 instance after posedge n showing vector vi.
  function automatic void push_scan(input int n, input int vi, input string nm);
    exp_t e;
    int   idx;
    idx = ((n - base) / 4) % 4;
    e.due = n; e.on_div1 = 1'b0;
    e.an = ~(4'b0001 << idx);
    e.seg = V_SEG[vi][idx];
    e.name = nm;
    sb.push_back(e);
  endfunction

  function automatic void push_rot(input int n);
    exp_t e;
    e.due = n; e.on_div1 = 1'b1;
    e.an = ~(4'b0001 << ((n - base) % 4));
    e.seg = 7'b0; e.name = "div1_rot";
    sb.push_back(e);
  endfunction

  // Called at a negedge. Loads vector a (and vector b on the following cycle
  // when b >= 0), then checks 16+extra cycles of scanning.
  task automatic load_vec(input int a, input int b, input int extra, input string nm);
    int k;
    int start;
    k = edge_no;
    bcd = V_BCD[a]; neg = V_NEG[a]; load = 1'b1;
    push_scan(k + 1, cur, {nm, "_old"});
    @(negedge clk);
    if (b >= 0) begin
      bcd = V_BCD[b]; neg = V_NEG[b];
      push_scan(k + 2, a, {nm, "_first"});
      @(negedge clk);
      cur = b; start = k + 3;
    end else begin
      cur = a; start = k + 2;
    end
    load = 1'b0;
    bcd = 12'($urandom);
    neg = 1'($urandom_range(0, 1));
    for (int n = start; n <= start + 15 + extra; n++) push_scan(n, cur, nm);
    while (edge_no < start + 15 + extra) @(negedge clk);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Monitor: pops every expectation due at this edge and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      edge_no++;
      while (sb.size() > 0 && sb[0].due <= edge_no) begin
        e = sb.pop_front();
        vectors++;
        if (e.due != edge_no) begin
          miscompares++;
          $display("FAIL %s: checked at edge %0d, required at edge %0d", e.name, edge_no, e.due);
        end else if (!e.on_div1) begin
          if (an0 !== e.an || seg0 !== e.seg || dp0 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s edge %0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                     e.name, edge_no, an0, seg0, dp0, e.an, e.seg);
          end
        end else begin
          if (an1 !== e.an || $countones(an1) != 3 || dp1 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s edge %0d: an=%b dp=%b, expected an=%b dp=1",
                     e.name, edge_no, an1, dp1, e.an);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int k;
    rst = 1'b1; load = 1'b1; bcd = 12'h999; neg = 1'b1;  // reset must beat load
    for (int n = 1; n <= 3; n++) push_reset(n);
    repeat (3) @(negedge clk);
    rst = 1'b0; load = 1'b0;
    base = edge_no + 1;
    cur = 0;
    for (int n = base; n <= base + 15; n++) push_scan(n, 0, "post_reset");
    while (edge_no < base + 15) @(negedge clk);

    load_vec(1, -1, 1, "v127");
    load_vec(2, -1, 2, "v005n");
    load_vec(3, -1, 0, "v0A0");
    load_vec(0, -1, 3, "v000");
    load_vec(4, 5, 1, "hold_F38_406");
    load_vec(1, -1, 2, "reload127");

    // Reset together with load in the middle of a scan.
    k = edge_no;
    rst = 1'b1; load = 1'b1; bcd = 12'h999; neg = 1'b1;
    push_reset(k + 1);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    base = k + 2;
    cur = 0;
    for (int n = base; n <= base + 15; n++) push_scan(n, 0, "midscan_rst");
    while (edge_no < base + 15) @(negedge clk);

    // DIV=1 instance: per-cycle rotation under random input activity.
    for (int i = 0; i < 1000; i++) begin
      bcd  = 12'($urandom);
      neg  = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 1));
      push_rot(edge_no + 1);
      @(negedge clk);
    end
    load = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    summary();
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: time limit reached at edge %0d, expected completion", edge_no);
    summary();
    $finish;
  end

endmodule
`default_nettype wire
